// File: rtl/ahb_calc_pkg.sv
// ahb_calc_pkg: AHB encodings, calculator register map and FSM state codes
package ahb_calc_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [31:0] OFF_A = 32'h0;
  localparam logic [31:0] OFF_B = 32'h4;
  localparam logic [31:0] OFF_OPC = 32'h8;
  localparam logic [31:0] OFF_RES = 32'hC;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_RSP = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ADDR = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  function automatic logic [31:0] reg_off(input logic [1:0] step);
    return step == 2'd0 ? OFF_A : step == 2'd1 ? OFF_B : step == 2'd2 ? OFF_OPC : OFF_RES;
  endfunction
endpackage

// File: rtl/ahb_calc_master_xfer.sv
// ahb_mst_xfer: one non-pipelined AHB single transfer with retry/split re-issue and response decode
module ahb_mst_xfer
  import ahb_calc_pkg::*;
#(
  parameter int MAX_RETRY = 4
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [1:0] phase;
  logic [RW-1:0] retry;
  logic give_up;
  assign give_up = hresp == HRESP_ERROR ||
                   ((hresp == HRESP_RETRY || hresp == HRESP_SPLIT) && retry == RW'(MAX_RETRY));
  assign done = phase == PH_DATA && hready && (hresp == HRESP_OKAY || give_up);
  assign err = phase == PH_DATA && hready && give_up;
  assign htrans = phase == PH_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr = addr;
  assign hwrite = phase == PH_ADDR && write;
  assign hwdata = phase == PH_DATA ? wdata : '0;
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      phase <= PH_IDLE;
      retry <= '0;
    end else if (phase == PH_ADDR) begin
      if (hready) phase <= PH_DATA;
    end else if (phase == PH_DATA && hready && !done) begin
      phase <= PH_ADDR;
      retry <= retry + 1'b1;
    end else if (phase == PH_IDLE || done) begin
      phase <= start ? PH_ADDR : PH_IDLE;
      retry <= '0;
    end
  end
endmodule

// File: rtl/ahb_calc_master.sv
// ahb_calc_master: runs write A, write B, write OPC, read RES on AHB for each accepted command
module ahb_calc_master
  import ahb_calc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 4
) (
  input  logic        hclk_i,
  input  logic        hresetn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_opcode_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic [1:0]  hresp_i
);
  logic [1:0] state, step, opcode;
  logic [15:0] a, b;
  logic start, done, err;
  logic [31:0] wdata;
  assign start = state == ST_IDLE ? cmd_valid_i : state == ST_RUN && done && !err && step != 2'd3;
  assign wdata = step == 2'd0 ? {16'h0, a} : step == 2'd1 ? {16'h0, b} :
                 step == 2'd2 ? {29'h0, 1'b1, opcode} : '0;
  assign cmd_ready_o = state == ST_IDLE;
  assign rsp_valid_o = state == ST_RSP;
  assign hsize_o = HSIZE_WORD;
  assign hburst_o = HBURST_SINGLE;
  ahb_mst_xfer #(.MAX_RETRY(MAX_RETRY)) u_xfer (
    .hclk(hclk_i),
    .hresetn(hresetn_i),
    .start(start),
    .addr(BASE_ADDR + reg_off(step)),
    .write(step != 2'd3),
    .wdata(wdata),
    .done(done),
    .err(err),
    .htrans(htrans_o),
    .haddr(haddr_o),
    .hwrite(hwrite_o),
    .hwdata(hwdata_o),
    .hready(hready_i),
    .hresp(hresp_i)
  );
  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      state <= ST_IDLE;
      step <= '0;
      opcode <= '0;
      a <= '0;
      b <= '0;
      rsp_data_o <= '0;
      rsp_err_o <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (cmd_valid_i) begin
        state <= ST_RUN;
        step <= '0;
        opcode <= cmd_opcode_i;
        a <= cmd_a_i;
        b <= cmd_b_i;
      end
    end else if (state == ST_RUN) begin
      if (done && (err || step == 2'd3)) begin
        state <= ST_RSP;
        rsp_err_o <= err;
        rsp_data_o <= err ? '0 : hrdata_i;
      end else if (done) begin
        step <= step + 1'b1;
      end
    end else if (rsp_ready_i) begin
      state <= ST_IDLE;
      step <= '0;
    end
  end
endmodule
